// File: rtl/rpsc_sequencer.sv
// rpsc_sequencer: power-up/power-down sequencer for the RPSC G1 and anode supplies.
//   Turns on G1 first and enables the anode only after G1 reports OK. Each wait
//   step has a timeout. Shutdown is ordered: the anode drops first and G1 follows
//   SHUTDOWN_DLY cycles later. The first fault is latched until it is acknowledged.
//   Optional build macro RPSC_SEQ_FAULT_CNT_EN adds a saturating fault_cnt output.
// Ports:
//   clk, reset (async, active-low)
//   start_req, stop_req, ack_fault                  operator controls
//   alarm_ok, g1_ok_n, th_an_ready_n, an_ok         card-2 interlock status
//   g1_ps_act, an_ps_act, ready, fault, fault_code, state   registered outputs
//   fault_cnt [3:0]                                 only with RPSC_SEQ_FAULT_CNT_EN
module rpsc_sequencer #(
  parameter int G1_TIMEOUT   = 256,
  parameter int AN_TIMEOUT   = 512,
  parameter int SHUTDOWN_DLY = 64,
  parameter int CNT_W        = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_req,
  input  logic       stop_req,
  input  logic       ack_fault,
  input  logic       alarm_ok,
  input  logic       g1_ok_n,
  input  logic       th_an_ready_n,
  input  logic       an_ok,
  output logic       g1_ps_act,
  output logic       an_ps_act,
  output logic       ready,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [2:0] state
`ifdef RPSC_SEQ_FAULT_CNT_EN
  ,
  output logic [3:0] fault_cnt
`endif
);
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    G1_WAIT  = 3'd1,
    AN_WAIT  = 3'd2,
    RUN      = 3'd3,
    SHUTDOWN = 3'd4,
    FAULT    = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] G1_LAST = CNT_W'(G1_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] AN_LAST = CNT_W'(AN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SD_LAST = CNT_W'(SHUTDOWN_DLY - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       code_q, code_d, cause;
  logic             g1_q, g1_d, an_q, an_d, ready_q, ready_d, fault_q, fault_d;
  logic             g1_to, an_to;

  // A timeout fires on the last permitted cycle only when that step's ok
  // condition is still absent, so a late success still wins.
  assign g1_to = state_q == G1_WAIT && g1_ok_n && cnt_q == G1_LAST;
  assign an_to = state_q == AN_WAIT && !an_ok && cnt_q == AN_LAST;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      code_q  <= 3'd0;
      g1_q    <= 1'b0;
      an_q    <= 1'b0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      g1_q    <= g1_d;
      an_q    <= an_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
    end
  end

  // Fault causes are ranked: alarm, thermal readiness, G1 lost, anode lost, then timeouts.
  // Any cause beats stop_req, and stop_req beats a success transition.
  always_comb begin
    state_d = state_q;
    cause   = 3'd0;
    case (state_q)
      IDLE: begin
        cause   = (start_req && !alarm_ok) ? 3'd1 : 3'd0;
        state_d = !start_req ? IDLE : alarm_ok ? G1_WAIT : FAULT;
      end
      G1_WAIT, AN_WAIT, RUN: begin
        cause = !alarm_ok                             ? 3'd1 :
                (th_an_ready_n && state_q != G1_WAIT) ? 3'd4 :
                (g1_ok_n && state_q == RUN)           ? 3'd5 :
                (!an_ok && state_q == RUN)            ? 3'd6 :
                g1_to                                 ? 3'd2 :
                an_to                                 ? 3'd3 : 3'd0;
        state_d = cause != 3'd0                         ? FAULT    :
                  stop_req                              ? SHUTDOWN :
                  (state_q == G1_WAIT && !g1_ok_n)      ? AN_WAIT  :
                  (state_q == AN_WAIT && an_ok)         ? RUN      : state_q;
      end
      SHUTDOWN: begin
        cause   = !alarm_ok ? 3'd1 : 3'd0;
        state_d = !alarm_ok ? FAULT : cnt_q == SD_LAST ? IDLE : SHUTDOWN;
      end
      FAULT:   state_d = (ack_fault && alarm_ok) ? IDLE : FAULT;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they move on the same edge as state.
  always_comb begin
    cnt_d   = state_d != state_q ? '0 :
              (state_q inside {G1_WAIT, AN_WAIT, SHUTDOWN}) ? cnt_q + CNT_W'(1) : cnt_q;
    code_d  = state_d != FAULT ? 3'd0 : state_q != FAULT ? cause : code_q;
    g1_d    = state_d inside {G1_WAIT, AN_WAIT, RUN, SHUTDOWN};
    an_d    = state_d inside {AN_WAIT, RUN};
    ready_d = state_d == RUN;
    fault_d = state_d == FAULT;
  end

  assign g1_ps_act  = g1_q;
  assign an_ps_act  = an_q;
  assign ready      = ready_q;
  assign fault      = fault_q;
  assign fault_code = code_q;
  assign state      = state_q;

`ifdef RPSC_SEQ_FAULT_CNT_EN
  logic [3:0] fcnt_q, fcnt_d;
  always_comb fcnt_d = (state_d == FAULT && state_q != FAULT && fcnt_q != 4'hf) ? fcnt_q + 4'd1 : fcnt_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) fcnt_q <= 4'd0;
    else        fcnt_q <= fcnt_d;
  end
  assign fault_cnt = fcnt_q;
`endif
endmodule

// File: tb/tb_rpsc_sequencer.sv
// tb_rpsc_sequencer: randomized and directed bench comparing rpsc_sequencer against a dwell-time model.
module tb_rpsc_sequencer;
  localparam int G1T = 8, ANT = 12, SD = 4;
  logic clk = 0, reset = 0;
  logic start_req = 0, stop_req = 0, ack_fault = 0;
  logic alarm_ok = 1, g1_ok_n = 1, th_an_ready_n = 0, an_ok = 0;
  logic g1_ps_act, an_ps_act, ready, fault;
  logic [2:0] fault_code, state;
  int total = 0, bad = 0;
  int m_st = 0, m_dw = 0, m_code = 0, m_fc = 0;
`ifdef RPSC_SEQ_FAULT_CNT_EN
  logic [3:0] fault_cnt;
`endif

  rpsc_sequencer #(.G1_TIMEOUT(G1T), .AN_TIMEOUT(ANT), .SHUTDOWN_DLY(SD), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start_req(start_req), .stop_req(stop_req), .ack_fault(ack_fault),
    .alarm_ok(alarm_ok), .g1_ok_n(g1_ok_n), .th_an_ready_n(th_an_ready_n), .an_ok(an_ok),
    .g1_ps_act(g1_ps_act), .an_ps_act(an_ps_act), .ready(ready), .fault(fault),
    .fault_code(fault_code), .state(state)
`ifdef RPSC_SEQ_FAULT_CNT_EN
    , .fault_cnt(fault_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Model: current mode, cycles already spent in it, latched cause.
  always @(posedge clk or negedge reset) begin : model
    int nx, nc;
    if (!reset) begin
      m_st = 0; m_dw = 0; m_code = 0; m_fc = 0;
    end else begin
      nx = m_st; nc = 0;
      if (m_st == 0) begin
        if (start_req) begin nx = alarm_ok ? 1 : 5; nc = alarm_ok ? 0 : 1; end
      end else if (m_st >= 1 && m_st <= 3) begin
        if (!alarm_ok) nc = 1;
        else if (th_an_ready_n && m_st != 1) nc = 4;
        else if (m_st == 3 && g1_ok_n) nc = 5;
        else if (m_st == 3 && !an_ok) nc = 6;
        else if (m_st == 1 && g1_ok_n && m_dw + 1 >= G1T) nc = 2;
        else if (m_st == 2 && !an_ok && m_dw + 1 >= ANT) nc = 3;
        if (nc != 0) nx = 5;
        else if (stop_req) nx = 4;
        else if (m_st == 1 && !g1_ok_n) nx = 2;
        else if (m_st == 2 && an_ok) nx = 3;
      end else if (m_st == 4) begin
        if (!alarm_ok) begin nx = 5; nc = 1; end
        else if (m_dw + 1 >= SD) nx = 0;
      end else if (ack_fault && alarm_ok) nx = 0;
      if (nx == 5 && m_st != 5) begin m_code = nc; if (m_fc < 15) m_fc++; end
      else if (nx != 5) m_code = 0;
      m_dw = (nx != m_st) ? 0 : m_dw + 1;
      m_st = nx;
    end
  end

  always @(negedge clk) begin
    logic [9:0] act, exp;
    act = {state, g1_ps_act, an_ps_act, ready, fault, fault_code};
    exp = {3'(m_st), m_st >= 1 && m_st <= 4, m_st == 2 || m_st == 3, m_st == 3, m_st == 5, 3'(m_code)};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL outs t=%0t got st=%0d g1=%b an=%b rdy=%b flt=%b code=%0d want st=%0d g1=%b an=%b rdy=%b flt=%b code=%0d",
               $time, act[9:7], act[6], act[5], act[4], act[3], act[2:0],
               exp[9:7], exp[6], exp[5], exp[4], exp[3], exp[2:0]);
    end
`ifdef RPSC_SEQ_FAULT_CNT_EN
    total++;
    if (fault_cnt !== 4'(m_fc)) begin
      bad++;
      $display("FAIL fault_cnt got %0d want %0d", fault_cnt, m_fc);
    end
`endif
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  initial begin
    int n;
    #3;
    chk("rst_state", state, 0); chk("rst_g1", g1_ps_act, 0); chk("rst_code", fault_code, 0);
    @(negedge clk) reset = 1;
    // nominal power-up
    @(negedge clk) start_req = 1;
    @(negedge clk) chk("nom_g1wait", state, 1); chk("nom_g1act", g1_ps_act, 1); chk("nom_an_off", an_ps_act, 0);
    start_req = 0;
    repeat (2) @(negedge clk);
    g1_ok_n = 0;
    @(negedge clk) chk("nom_anwait", state, 2); chk("nom_anact", an_ps_act, 1);
    repeat (4) @(negedge clk);
    an_ok = 1;
    @(negedge clk) chk("nom_run", state, 3); chk("nom_ready", ready, 1); chk("nom_nofault", fault, 0);
    // alarm beats stop in the same cycle, then ack gating
    alarm_ok = 0; stop_req = 1;
    @(negedge clk) chk("alm_state", state, 5); chk("alm_code", fault_code, 1); chk("alm_g1", g1_ps_act, 0);
    stop_req = 0; ack_fault = 1;
    @(negedge clk) chk("ack_ignored", state, 5);
    alarm_ok = 1;
    @(negedge clk) chk("ack_idle", state, 0); chk("ack_code", fault_code, 0);
    ack_fault = 0;
    // ordered shutdown
    start_req = 1;
    @(negedge clk) start_req = 0;
    repeat (2) @(negedge clk);
    chk("sd_run", state, 3);
    stop_req = 1;
    @(negedge clk) chk("sd_state", state, 4); chk("sd_an_off", an_ps_act, 0); chk("sd_g1_on", g1_ps_act, 1);
    stop_req = 0;
    n = 0;
    while (g1_ps_act && n < 20) begin @(negedge clk); n++; end
    chk("sd_g1_hold", n, SD); chk("sd_idle", state, 0);
    // G1 timeout
    g1_ok_n = 1; an_ok = 0; start_req = 1;
    @(negedge clk) start_req = 0; chk("g1to_enter", state, 1);
    n = 0;
    while (state == 1 && n < 30) begin @(negedge clk); n++; end
    chk("g1to_cycles", n, G1T); chk("g1to_code", fault_code, 2); chk("g1to_g1", g1_ps_act, 0);
    ack_fault = 1;
    @(negedge clk) ack_fault = 0; chk("g1to_clear", state, 0);
    // anode timeout
    g1_ok_n = 0; start_req = 1;
    @(negedge clk) start_req = 0;
    @(negedge clk) chk("anto_enter", state, 2);
    n = 0;
    while (state == 2 && n < 30) begin @(negedge clk); n++; end
    chk("anto_cycles", n, ANT); chk("anto_code", fault_code, 3);
    ack_fault = 1;
    @(negedge clk) ack_fault = 0;
    // asynchronous reset in AN_WAIT
    start_req = 1;
    @(negedge clk) start_req = 0;
    @(negedge clk) chk("arst_pre", state, 2);
    #2 reset = 0;
    #1 chk("arst_g1", g1_ps_act, 0); chk("arst_an", an_ps_act, 0); chk("arst_state", state, 0);
    @(negedge clk) reset = 1;
`ifdef RPSC_SEQ_FAULT_CNT_EN
    for (int i = 0; i < 17; i++) begin
      alarm_ok = 0; start_req = 1;
      @(negedge clk) start_req = 0; alarm_ok = 1; ack_fault = 1;
      @(negedge clk) ack_fault = 0;
    end
    chk("fcnt_sat", fault_cnt, 15);
`endif
    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start_req = $urandom_range(0, 9) == 0;
      stop_req  = $urandom_range(0, 39) == 0;
      ack_fault = $urandom_range(0, 7) == 0;
      if (!alarm_ok) alarm_ok = $urandom_range(0, 2) == 0;
      else alarm_ok = $urandom_range(0, 79) != 0;
      if ($urandom_range(0, 5) == 0) g1_ok_n = ~g1_ok_n;
      if ($urandom_range(0, 5) == 0) an_ok = ~an_ok;
      if (th_an_ready_n) th_an_ready_n = $urandom_range(0, 1) == 0;
      else th_an_ready_n = $urandom_range(0, 49) == 0;
    end
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
